// File: rtl/fetch_queue.sv
// Instruction-fetch stage: drives the external PC register and issues one-cycle-latency imem reads.
// Fetched {pc, instr} pairs are buffered for decode. Optional counters under FETCH_PERF_EN.
module fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] pc_cur,
   output logic [31:0] pc_next,
   output logic        imem_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall
`endif
);

   localparam int AW = $clog2(QDEPTH);

   logic [AW:0]   count_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW-1:0] wr_ptr_reg;
   logic          inflight_reg;
   logic [31:0]   inflight_pc_reg;

   logic [31:0]   pc_mem    [QDEPTH];
   logic [31:0]   instr_mem [QDEPTH];

   logic [AW+1:0] occupancy;
   logic          issue;
   logic          push;
   logic          pop;

   // Alignment bits of the redirect target are deliberately discarded.
   logic unused_target_bits;
   assign unused_target_bits = ^redirect_target[1:0];

   // Reserve a slot for the outstanding read so a push can never find the FIFO full.
   assign occupancy = {1'b0, count_reg} + {{(AW+1){1'b0}}, inflight_reg};
   assign issue     = !i_rst && !redirect_valid && (occupancy < (AW+2)'(QDEPTH));
   assign imem_en   = issue;
   assign imem_addr = pc_cur;

   assign push = inflight_reg && !redirect_valid && !i_rst;
   assign pop  = id_valid && id_ready;

   always_comb begin
      pc_next = pc_cur;
      if (i_rst)
         pc_next = RESET_PC;
      else if (redirect_valid)
         pc_next = {redirect_target[31:2], 2'b00};
      else if (issue)
         pc_next = pc_cur + 32'd4;
   end

   assign id_valid = (count_reg != '0);
   assign id_pc    = id_valid ? pc_mem[rd_ptr_reg]    : 32'd0;
   assign id_instr = id_valid ? instr_mem[rd_ptr_reg] : 32'd0;

   always_ff @(posedge i_clk) begin
      if (push) begin
         pc_mem[wr_ptr_reg]    <= inflight_pc_reg;
         instr_mem[wr_ptr_reg] <= imem_rdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count_reg       <= '0;
         rd_ptr_reg      <= '0;
         wr_ptr_reg      <= '0;
         inflight_reg    <= 1'b0;
         inflight_pc_reg <= 32'd0;
      end else if (redirect_valid) begin
         // Flush: queue empties and the outstanding read's data is dropped.
         count_reg    <= '0;
         rd_ptr_reg   <= wr_ptr_reg;
         inflight_reg <= 1'b0;
      end else begin
         inflight_reg <= issue;
         if (issue)
            inflight_pc_reg <= pc_cur;
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         perf_fetched <= 32'd0;
         perf_stall   <= 32'd0;
      end else begin
         if (push && (perf_fetched != 32'hFFFF_FFFF))
            perf_fetched <= perf_fetched + 32'd1;
         if (id_valid && !id_ready && (perf_stall != 32'hFFFF_FFFF))
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule
